// File: rtl/tpu_host_sequencer.sv
// Bus initiator that runs one TPU matrix job: load A/B/C, start, wait, read C back.
// Define TPU_SEQ_CLOAD_EN to stream the C initial values instead of clearing C.
module tpu_host_sequencer #(
    parameter int DIM         = 8,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 3*DIM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_wdata,
    input  logic [DATAW-1:0] tpu_rdata
);
    localparam int IW = $clog2(2*DIM) + 1;
    localparam int WW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [IW-1:0]    AB_LAST    = IW'(DIM - 1);
    localparam logic [IW-1:0]    C_LAST     = IW'(2*DIM - 1);
    localparam logic [IW-1:0]    C_COUNT    = IW'(2*DIM);
    localparam logic [ADDRW-1:0] A_BASE     = ADDRW'(12'h100);
    localparam logic [ADDRW-1:0] B_BASE     = ADDRW'(12'h200);
    localparam logic [ADDRW-1:0] C_BASE     = ADDRW'(12'h300);
    localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(12'h400);

    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, LOAD_C, START, WAIT, READ_C, DRAIN, DONE
    } state_t;

    state_t            state, state_d;
    logic [IW-1:0]     idx, idx_d;
    logic [WW-1:0]     wcnt, wcnt_d;
    logic              rd_pend, rd_pend_d;
    logic              busy_d, done_d, in_ready_d, out_valid_d, r_w_d;
    logic [DATAW-1:0]  out_data_d, wdata_d;
    logic [ADDRW-1:0]  addr_d;
    logic              xfer, hs;

    assign xfer = in_valid & in_ready;
    assign hs   = out_valid & out_ready;

    function automatic logic [ADDRW-1:0] row_addr(input logic [ADDRW-1:0] base, input logic [IW-1:0] i);
        return base + ADDRW'({i, 3'b000});
    endfunction

    // Even idx is the low half-row, odd idx the high half-row.
    function automatic logic [ADDRW-1:0] c_addr(input logic [IW-1:0] i);
        return C_BASE + (ADDRW'(i >> 1) << 4) + (ADDRW'(i[0]) << 3);
    endfunction

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        wcnt_d      = wcnt;
        rd_pend_d   = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        r_w_d       = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_A;
                    busy_d     = 1'b1;
                    idx_d      = '0;
                    in_ready_d = 1'b1;
                end
            end
            LOAD_A: begin
                if (xfer) begin
                    r_w_d   = 1'b1;
                    addr_d  = row_addr(A_BASE, idx);
                    wdata_d = in_data;
                    if (idx == AB_LAST) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    r_w_d   = 1'b1;
                    addr_d  = row_addr(B_BASE, idx);
                    wdata_d = in_data;
                    if (idx == AB_LAST) begin
                        idx_d   = '0;
                        state_d = LOAD_C;
`ifndef TPU_SEQ_CLOAD_EN
                        in_ready_d = 1'b0;
`endif
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            LOAD_C: begin
`ifdef TPU_SEQ_CLOAD_EN
                if (xfer) begin
                    r_w_d   = 1'b1;
                    addr_d  = c_addr(idx);
                    wdata_d = in_data;
                    if (idx == C_LAST) begin
                        idx_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = START;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
`else
                // Clear C with back-to-back zero writes; no input consumed.
                r_w_d  = 1'b1;
                addr_d = c_addr(idx);
                if (idx == C_LAST) begin
                    idx_d   = '0;
                    state_d = START;
                end else begin
                    idx_d = idx + 1'b1;
                end
`endif
            end
            START: begin
                r_w_d   = 1'b1;
                addr_d  = START_ADDR;
                wcnt_d  = WW'(WAIT_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt == '0) state_d = READ_C;
                else            wcnt_d  = wcnt - 1'b1;
            end
            READ_C: begin
                if (hs) out_valid_d = 1'b0;
                // One read in flight at a time, so the capture slot is always free.
                if (rd_pend) begin
                    out_data_d  = tpu_rdata;
                    out_valid_d = 1'b1;
                    if (idx == C_COUNT) state_d = DRAIN;
                end else if (!out_valid || hs) begin
                    addr_d    = c_addr(idx);
                    rd_pend_d = 1'b1;
                    idx_d     = idx + 1'b1;
                end
            end
            DRAIN: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            wcnt      <= '0;
            rd_pend   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tpu_r_w   <= 1'b0;
            tpu_addr  <= '0;
            tpu_wdata <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            wcnt      <= wcnt_d;
            rd_pend   <= rd_pend_d;
            busy      <= busy_d;
            done      <= done_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            tpu_r_w   <= r_w_d;
            tpu_addr  <= addr_d;
            tpu_wdata <= wdata_d;
        end
    end
endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Bench for tpu_host_sequencer: a TPU stand-in on the bus, a table-driven identity job,
// hand sequences for stalls/reset, and random jobs checked against a matrix-level model.
module tb_tpu_host_sequencer;
    localparam int DIM = 8;
    localparam int WAIT_CYCLES = 3*DIM;
`ifdef TPU_SEQ_CLOAD_EN
    localparam int NIN = 4*DIM;
    localparam bit CLOAD = 1'b1;
`else
    localparam int NIN = 2*DIM;
    localparam bit CLOAD = 1'b0;
`endif
    localparam int NOUT = 2*DIM;
    localparam int NWR  = 4*DIM + 1;

    typedef logic [63:0] rows_t [8];
    typedef struct { logic [63:0] din; logic [63:0] dout; } vec_t;
    typedef struct { logic [15:0] a; logic [63:0] d; } wr_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] tpu_rdata, out_data, tpu_wdata;
    logic        busy, done, in_ready, out_valid, tpu_r_w;
    logic [15:0] tpu_addr;

    always #5 clk = ~clk;

    tpu_host_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // C = C0 + A*B for one half-row h (row h/2, columns (h&1)*4 .. +3), 16-bit lanes.
    function automatic logic [63:0] mm_half(input rows_t a, input rows_t b, input logic [63:0] c0, input int h);
        logic [63:0] res;
        logic [15:0] acc;
        int r, c;
        r = h / 2;
        for (int j = 0; j < 4; j++) begin
            c = (h % 2) * 4 + j;
            acc = c0[16*j +: 16];
            for (int k = 0; k < 8; k++)
                acc = acc + 16'(a[r][8*k +: 8]) * 16'(b[k][8*c +: 8]);
            res[16*j +: 16] = acc;
        end
        return res;
    endfunction

    // TPU stand-in: stores writes, computes C on the start write, returns C reads combinationally.
    rows_t       amem = '{default: '0};
    rows_t       bmem = '{default: '0};
    logic [63:0] cmem [16] = '{default: '0};
    logic [63:0] cres [16] = '{default: '0};
    int cyc = 0, n400 = 0, t400 = 0, first_rd = -1, bad_bus = 0;
    wr_t wlog[$];

    assign tpu_rdata = (tpu_addr[15:7] == 9'd6) ? cres[tpu_addr[6:3]] : 64'd0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tpu_r_w) begin
            wlog.push_back('{tpu_addr, tpu_wdata});
            if (tpu_addr[15:6] == 10'h004)      amem[tpu_addr[5:3]] <= tpu_wdata;
            else if (tpu_addr[15:6] == 10'h008) bmem[tpu_addr[5:3]] <= tpu_wdata;
            else if (tpu_addr[15:7] == 9'd6)    cmem[tpu_addr[6:3]] <= tpu_wdata;
            else if (tpu_addr == 16'h0400)
                for (int i = 0; i < 16; i++) cres[i] <= mm_half(amem, bmem, cmem[i], i);
        end
        if (tpu_addr == 16'h0400) begin
            n400     <= n400 + 1;
            t400     <= cyc;
            first_rd <= -1;
            if (!tpu_r_w) bad_bus <= bad_bus + 1;
        end else if (tpu_addr != 16'h0 && (tpu_addr[2:0] != 3'd0 ||
                 (!tpu_r_w && tpu_addr[15:7] != 9'd6))) begin
            bad_bus <= bad_bus + 1;
        end else if (!tpu_r_w && tpu_addr != 16'h0 && first_rd < 0) begin
            first_rd <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, 64'({busy, done, in_ready, out_valid, tpu_r_w}), 64'd0);
        chk({nm, "_addr"}, 64'(tpu_addr), 64'd0);
        chk({nm, "_wdata"}, tpu_wdata, 64'd0);
        chk({nm, "_out_data"}, out_data, 64'd0);
    endtask

    logic [63:0] stream[$];
    logic [63:0] exp_out[$];

    task automatic random_job();
        rows_t a, b;
        stream.delete();
        exp_out.delete();
        for (int i = 0; i < NIN; i++) stream.push_back({$urandom, $urandom});
        for (int i = 0; i < 8; i++) begin
            a[i] = stream[i];
            b[i] = stream[DIM + i];
        end
        for (int h = 0; h < NOUT; h++)
            exp_out.push_back(mm_half(a, b, CLOAD ? stream[2*DIM + (h % (NIN - DIM))] : 64'd0, h));
    endtask

    // vmode: 0 always valid, 1 toggle, 2 random. stall_idx: output index held off 5 cycles.
    task automatic run_job(input int vmode, input int rpct, input int stall_idx, input bit poke_start);
        int sent, got, stall_n, wbase, n400_0, bad0, ndone, post;
        bit prev_ov, prev_or, v;
        logic [63:0] prev_d;
        logic [15:0] prev_a;
        wbase = wlog.size();
        n400_0 = n400;
        bad0 = bad_bus;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_on_start", 64'(busy), 64'd1);
        sent = 0; got = 0; stall_n = 0; ndone = 0; post = 0;
        prev_ov = 1'b0; prev_or = 1'b0; prev_d = '0; prev_a = '0;
        for (int ncyc = 0; ncyc < 3000; ncyc++) begin
            if (prev_ov && !prev_or) begin
                chk("out_hold_valid", 64'(out_valid), 64'd1);
                chk("out_hold_data", out_data, prev_d);
                chk("stall_new_read", 64'(!tpu_r_w && tpu_addr != 16'h0 && tpu_addr != prev_a), 64'd0);
            end
            if (done) begin
                ndone++;
                chk("done_after_last", 64'(got), 64'(NOUT));
            end
            if (ndone > 0) begin
                post++;
                if (post > 3) break;
            end
            start = (poke_start && ncyc == 5);
            if (sent < NIN) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (ncyc % 2 == 0);
                    default: v = ($urandom_range(99) < 70);
                endcase
                in_valid = v;
                in_data  = v ? stream[sent] : {$urandom, $urandom};
                if (v && in_ready) sent++;
            end else begin
                in_valid = 1'b0;
                chk("in_ready_low_after_stream", 64'(in_ready), 64'd0);
            end
            if (out_valid && got == stall_idx && stall_n < 5) begin
                out_ready = 1'b0;
                stall_n++;
            end else begin
                out_ready = (rpct >= 100) || ($urandom_range(99) < rpct);
            end
            if (out_valid && out_ready) begin
                if (got < NOUT) chk("out_data", out_data, exp_out[got]);
                else chk("extra_output", 64'(got), 64'(NOUT - 1));
                got++;
            end
            prev_ov = out_valid; prev_or = out_ready; prev_d = out_data; prev_a = tpu_addr;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("done_pulses", 64'(ndone), 64'd1);
        chk("outputs_delivered", 64'(got), 64'(NOUT));
        chk("inputs_consumed", 64'(sent), 64'(NIN));
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("start_addr_cycles", 64'(n400 - n400_0), 64'd1);
        chk("first_read_delay", 64'(first_rd - t400), 64'(WAIT_CYCLES + 1));
        chk("bus_violations", 64'(bad_bus - bad0), 64'd0);
        chk("write_count", 64'(wlog.size() - wbase), 64'(NWR));
        for (int i = 0; i < NWR && wbase + i < wlog.size(); i++) begin
            logic [15:0] ea;
            logic [63:0] ed;
            if (i < DIM) begin
                ea = 16'h0100 + 16'(8*i); ed = stream[i];
            end else if (i < 2*DIM) begin
                ea = 16'h0200 + 16'(8*(i - DIM)); ed = stream[i];
            end else if (i < 4*DIM) begin
                ea = 16'h0300 + 16'(16*((i - 2*DIM) / 2) + 8*((i - 2*DIM) % 2));
                if (CLOAD) ed = stream[i]; else ed = 64'd0;
            end else begin
                ea = 16'h0400; ed = 64'd0;
            end
            chk("write_addr", 64'(wlog[wbase + i].a), 64'(ea));
            chk("write_data", wlog[wbase + i].d, ed);
        end
    endtask

    vec_t tbl [2*DIM];

    initial begin
        int sent;
        // Identity A, B row r = r+1 in every byte: C half-rows of row r are r+1 in every lane.
        for (int i = 0; i < 2*DIM; i++) begin
            tbl[i].din  = (i < DIM) ? (64'd1 << (8*i)) : {8{8'(i - DIM + 1)}};
            tbl[i].dout = {4{16'(i/2 + 1)}};
        end

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_bus", 64'({tpu_r_w, tpu_addr, busy, in_ready, out_valid, done}), 64'd0);
        end
        chk("idle_no_start_addr", 64'(n400), 64'd0);

        stream.delete();
        exp_out.delete();
        for (int i = 0; i < 2*DIM; i++) begin
            stream.push_back(tbl[i].din);
            exp_out.push_back(tbl[i].dout);
        end
        if (CLOAD) for (int i = 0; i < 2*DIM; i++) stream.push_back(64'd0);
        run_job(0, 100, -1, 1'b0);
        run_job(1, 100, -1, 1'b1);
        run_job(0, 100, 2, 1'b0);

        // Reset in LOAD_B, right after the write of B row 1 is presented.
        random_job();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        sent = 0;
        for (int n = 0; n < 100 && sent < DIM + 2; n++) begin
            in_valid = 1'b1;
            in_data  = stream[sent];
            if (in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_reset_write_addr", 64'({tpu_r_w, tpu_addr}), 64'({1'b1, 16'h0208}));
        rst = 1'b1;
        #1;
        chk_reset("reset_mid_job");
        @(negedge clk); rst = 1'b0;
        repeat (30) @(negedge clk);
        random_job();
        run_job(0, 100, -1, 1'b0);

        for (int j = 0; j < 4; j++) begin
            random_job();
            run_job(2, 60, (j == 1) ? int'($urandom_range(NOUT - 1)) : -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
